tqvp_prism_loader: RTL

//  Sequencer and arbiter for the PRISM debug/config write port inside the TinyQV peripheral.

---
 rtl/tqvp_prism_loader.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/tqvp_prism_loader.sv
// PRISM debug/config port sequencer: host passthrough while idle, otherwise replays a
// staged FIFO burst into consecutive word addresses with PRISM held in reset.
module tqvp_prism_loader #(
  parameter int DEPTH      = 8,
  parameter int WR_GAP     = 3,
  parameter int RST_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  host_addr,
  input  logic [31:0] host_wdata,
  input  logic        host_wr,
  output logic        host_ready,
  input  logic        fifo_push,
  input  logic [31:0] fifo_data,
  output logic        fifo_full,
  output logic [4:0]  fifo_level,
  input  logic        start,
  input  logic [5:0]  start_addr,
  input  logic        abort,
  output logic [5:0]  prism_addr,
  output logic [31:0] prism_wdata,
  output logic        prism_wr,
  output logic        prism_reset,
  output logic        prism_enable,
  output logic        busy,
  output logic        done_irq,
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RST  = 3'd1,
    S_LOAD = 3'd2,
    S_GAP  = 3'd3,
    S_ENA  = 3'd4
  } state_t;

  state_t        state_r, next_state_s;
  logic [7:0]    cnt_r;
  logic [5:0]    addr_ptr_r;
  logic [31:0]   mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r, wr_ptr_r;
  logic [4:0]    level_r;
  logic          err_r, enable_r, abort_hold_r;
  logic          idle_s, empty_s, full_s, pop_s, flush_s, start_ok_s;
  logic          push_ok_s, push_drop_s, err_set_s, err_clr_s;

  assign idle_s      = (state_r == S_IDLE);
  assign empty_s     = (level_r == 5'd0);
  assign full_s      = (level_r == 5'(DEPTH));
  assign pop_s       = (state_r == S_LOAD);
  // Abort only means something once the loader owns the port; in IDLE a start wins.
  assign flush_s     = abort && !idle_s;
  assign start_ok_s  = start && idle_s;
  assign push_ok_s   = fifo_push && !flush_s && (!full_s || pop_s);
  assign push_drop_s = fifo_push && !flush_s && full_s && !pop_s;
  assign err_set_s   = (host_wr && !idle_s) || push_drop_s || flush_s;
  assign err_clr_s   = start_ok_s ||
                       (idle_s && host_wr && (host_addr == 6'h3C) && host_wdata[31]);

  // Next-state logic for the load sequence.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) next_state_s = S_RST;
        else       next_state_s = S_IDLE;
      end
      S_RST: begin
        if (cnt_r == 8'(RST_CYCLES - 1)) next_state_s = empty_s ? S_ENA : S_LOAD;
        else                             next_state_s = S_RST;
      end
      S_LOAD: next_state_s = S_GAP;
      S_GAP: begin
        if (cnt_r == 8'(WR_GAP - 2)) next_state_s = empty_s ? S_ENA : S_LOAD;
        else                         next_state_s = S_GAP;
      end
      S_ENA:   next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
    if (flush_s) begin
      next_state_s = S_IDLE;
    end else begin
      next_state_s = next_state_s;
    end
  end

  // State register and per-state cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= next_state_s;
      if (next_state_s != state_r)                    cnt_r <= 8'd0;
      else if (state_r == S_RST || state_r == S_GAP)  cnt_r <= cnt_r + 8'd1;
      else                                            cnt_r <= cnt_r;
    end
  end

  // Target address pointer, error flag, enable and post-abort reset hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_ptr_r   <= 6'd0;
      err_r        <= 1'b0;
      enable_r     <= 1'b0;
      abort_hold_r <= 1'b0;
    end else begin
      if (start_ok_s) addr_ptr_r <= start_addr;
      else if (pop_s) addr_ptr_r <= addr_ptr_r + 6'd4;
      else            addr_ptr_r <= addr_ptr_r;

      if (err_set_s)      err_r <= 1'b1;
      else if (err_clr_s) err_r <= 1'b0;
      else                err_r <= err_r;

      if (start_ok_s || flush_s)     enable_r <= 1'b0;
      else if (next_state_s == S_ENA) enable_r <= 1'b1;
      else                            enable_r <= enable_r;

      abort_hold_r <= flush_s;
    end
  end

  // FIFO pointers and occupancy; abort flushes everything staged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      level_r  <= 5'd0;
    end else if (flush_s) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      level_r  <= 5'd0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)     rd_ptr_r <= rd_ptr_r + AW'(1);
      level_r <= level_r + 5'(push_ok_s) - 5'(pop_s);
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= fifo_data;
  end

  // Port mux: host passthrough in IDLE, loader drive otherwise.
  always_comb begin
    prism_addr  = host_addr;
    prism_wdata = host_wdata;
    prism_wr    = host_wr;
    if (idle_s) begin
      prism_addr  = host_addr;
      prism_wdata = host_wdata;
      prism_wr    = host_wr;
    end else if (pop_s) begin
      prism_addr  = addr_ptr_r;
      prism_wdata = mem_r[rd_ptr_r];
      prism_wr    = 1'b1;
    end else begin
      prism_addr  = addr_ptr_r;
      prism_wdata = 32'd0;
      prism_wr    = 1'b0;
    end
  end

  assign busy         = !idle_s;
  assign host_ready   = idle_s;
  assign prism_reset  = (state_r == S_RST) || (state_r == S_LOAD) || (state_r == S_GAP) ||
                        abort_hold_r;
  assign prism_enable = enable_r;
  assign done_irq     = (state_r == S_ENA) && !abort;
  assign err          = err_r;
  assign fifo_full    = full_s;
  assign fifo_level   = level_r;

endmodule
